// File: rtl/ariane_irq_gateway_if.sv
`default_nettype none
// ============================================================================
// Module   : ariane_irq_gateway_if
// Brief    : Claim/complete bus between the interrupt gateway and PLIC core.
// Revision : 1.0 - initial release
// ============================================================================

interface ariane_irq_gateway_if #(
    parameter int ID_W = 5
);
    logic            max_valid_o;
    logic [ID_W-1:0] max_id_o;
    logic            claim_i;
    logic            complete_i;
    logic [ID_W-1:0] complete_id_i;

    // master: claim logic in the PLIC core; slave: the gateway
    modport master (
        input  max_valid_o,
        input  max_id_o,
        output claim_i,
        output complete_i,
        output complete_id_i
    );

    modport slave (
        output max_valid_o,
        output max_id_o,
        input  claim_i,
        input  complete_i,
        input  complete_id_i
    );
endinterface

`default_nettype wire

// File: rtl/ariane_irq_gateway.sv
`default_nettype none
// ============================================================================
// Module   : ariane_irq_gateway
// Brief    : Per-source interrupt gateway (sync, level/edge capture, claim/
//            complete sequencing) with fixed-priority pending selection.
// Revision : 1.0 - initial release
// ============================================================================

module ariane_irq_gateway #(
    parameter int NUM_SRC     = 30,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_CNT_W  = 2,
    parameter int ID_W        = $clog2(NUM_SRC)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_SRC-1:0]   irq_src_i,
    input  logic [NUM_SRC-1:0]   edge_mode_i,
    output logic [NUM_SRC-1:0]   ip_o,
    ariane_irq_gateway_if.slave  bus
);

    localparam logic [1:0]            S_IDLE     = 2'b00;
    localparam logic [1:0]            S_PENDING  = 2'b01;
    localparam logic [1:0]            S_INFLIGHT = 2'b10;
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX    = {EDGE_CNT_W{1'b1}};

    logic [NUM_SRC-1:0] w_ip;
    logic               w_max_valid;
    logic [ID_W-1:0]    w_max_id;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_req_d;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [EDGE_CNT_W-1:0]  r_cnt;
        logic [EDGE_CNT_W-1:0]  w_cnt_nxt;
        logic                   w_raw;
        logic                   w_req;
        logic                   w_rise;
        logic                   w_edge;
        logic                   w_claim;
        logic                   w_complete;
        logic                   w_consume;
        logic                   w_pend;

        // Source 0 is reserved: its line is forced low so it never leaves IDLE.
        assign w_raw  = (s != 0) && irq_src_i[s];
        assign w_edge = edge_mode_i[s];
        assign w_req  = r_sync[SYNC_STAGES-1];
        assign w_rise = w_req & ~r_req_d;

        assign w_claim    = bus.claim_i && w_max_valid && (w_max_id == ID_W'(s));
        assign w_complete = bus.complete_i && (bus.complete_id_i == ID_W'(s));

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_sync  <= '0;
                r_req_d <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw};
                r_req_d <= w_req;
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_consume   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        // A fresh edge is consumed directly; otherwise drain the backlog.
                        if (w_rise) begin
                            w_state_nxt = S_PENDING;
                            w_consume   = 1'b1;
                        end else if (r_cnt != '0) begin
                            w_state_nxt = S_PENDING;
                            w_cnt_nxt   = r_cnt - EDGE_CNT_W'(1);
                        end
                    end else if (w_req) begin
                        w_state_nxt = S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (w_claim) begin
                        w_state_nxt = S_INFLIGHT;
                    end
                end
                S_INFLIGHT: begin
                    if (w_complete) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_edge && w_rise && !w_consume && (r_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_cnt + EDGE_CNT_W'(1);
            end
        end

        always_comb begin
            w_pend = (r_state == S_PENDING);
        end

        assign w_ip[s] = w_pend;
    end

    // Lowest index wins: scan downward so the last hit is the smallest id.
    always_comb begin
        w_max_id = '0;
        for (int i = NUM_SRC - 1; i >= 1; i--) begin
            if (w_ip[i]) begin
                w_max_id = ID_W'(i);
            end
        end
    end

    assign w_max_valid     = |w_ip[NUM_SRC-1:1];
    assign bus.max_valid_o = w_max_valid;
    assign bus.max_id_o    = w_max_id;
    assign ip_o            = w_ip;

endmodule

`default_nettype wire
